// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART byte
// transmitter between several requesters, with an idle gap and length cap.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 234,
  parameter int MAX_BYTES  = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 trunc_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        last_idx_q, last_idx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic                 trunc_q, trunc_d;

  logic [IW-1:0]        winner;
  logic                 xfer;
  logic [7:0]           cnt_inc;

  // Nearest requester after last_idx wins: scan farthest first, nearest overwrites
  always_comb begin
    int idx;
    winner = last_idx_q;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(last_idx_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid_i[IW'(idx)]) winner = IW'(idx);
    end
  end

  // Datapath mux from the granted requester; quiet outside XFER
  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    req_ready_o = '0;
    if (state_q == XFER) begin
      tx_valid_o              = req_valid_i[last_idx_q];
      tx_data_o               = req_data_i[{last_idx_q, 3'b000} +: 8];
      req_ready_o[last_idx_q] = tx_ready_i;
    end
  end

  assign xfer    = tx_valid_o & tx_ready_i;
  assign cnt_inc = byte_cnt_q + 8'd1;

  // Next-state: arbitration, byte counting, release and gap timing
  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    grant_d    = grant_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    trunc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          state_d    = XFER;
          last_idx_d = winner;
          grant_d    = NUM_REQ'(1) << winner;
          byte_cnt_d = 8'd0;
        end
      end
      XFER: begin
        if (xfer) begin
          byte_cnt_d = cnt_inc;
          if (req_last_i[last_idx_q] || cnt_inc == MAX_CNT) begin
            trunc_d   = ~req_last_i[last_idx_q];
            grant_d   = '0;
            gap_cnt_d = '0;
            state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      last_idx_q <= LAST_RST;
      grant_q    <= '0;
      byte_cnt_q <= 8'd0;
      gap_cnt_q  <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      grant_q    <= grant_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);
  assign trunc_o = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: per-requester byte
// queues plus a packet-level reference model of grant, gap and truncation.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int GAP  = 5;
  localparam int MAXB = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } byte_t;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N-1:0]   req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_last_i;
  logic [N-1:0]   req_ready_o;
  logic [7:0]     tx_data_o;
  logic           tx_valid_o;
  logic           tx_ready_i;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           trunc_o;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .GAP_CYCLES(GAP),
    .MAX_BYTES(MAXB)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .req_valid_i(req_valid_i),
    .req_data_i(req_data_i),
    .req_last_i(req_last_i),
    .req_ready_o(req_ready_o),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .grant_o(grant_o),
    .busy_o(busy_o),
    .trunc_o(trunc_o)
  );

  always #5 clk = ~clk;

  byte_t src_q [N][$];
  byte_t exp_q [N][$];

  int checks   = 0;
  int failures = 0;
  int pv       = 100;
  int rdy_pct  = 100;

  // Reference model: owner (-1 = none), gap cycles left, bytes this grant
  int m_owner = -1;
  int m_gap   = 0;
  int m_cnt   = 0;
  int m_last  = N - 1;
  bit m_trunc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, req, $time);
    end
  endtask

  task automatic push_byte(input int k, input logic [7:0] d, input bit l);
    byte_t b;
    b.d = d;
    b.l = l;
    src_q[k].push_back(b);
    exp_q[k].push_back(b);
  endtask

  task automatic push_pkt(input int k, input int len);
    for (int i = 0; i < len; i++)
      push_byte(k, 8'($urandom), (i == len - 1));
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += exp_q[k].size();
    return s;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0 && $urandom_range(0, 99) < pv) begin
        req_valid_i[k]        = 1'b1;
        req_data_i[8*k +: 8]  = src_q[k][0].d;
        req_last_i[k]         = src_q[k][0].l;
      end else begin
        req_valid_i[k]        = 1'b0;
        req_data_i[8*k +: 8]  = 8'($urandom);
        req_last_i[k]         = 1'($urandom);
      end
    end
    tx_ready_i = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 drive();
    end
  endtask

  task automatic do_reset();
    reset_i     = 1'b1;
    req_valid_i = '0;
    tx_ready_i  = 1'($urandom);
    @(posedge clk);
    #1 reset_i = 1'b0;
    drive();
  endtask

  // Monitor: compare outputs to the model, pop scoreboard on transfers
  always @(negedge clk) begin : mon
    logic [N-1:0] eg;
    bit           ev;
    byte_t        b;
    int           idx;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    ev = (m_owner >= 0) ? req_valid_i[m_owner] : 1'b0;
    chk("grant", grant_o, eg);
    chk("busy", busy_o, (m_owner >= 0 || m_gap > 0));
    chk("trunc", trunc_o, m_trunc);
    chk("tx_valid", tx_valid_o, ev);
    chk("req_ready", req_ready_o, tx_ready_i ? eg : '0);
    if (m_owner < 0) chk("tx_data_idle", tx_data_o, 0);
    else if (ev && exp_q[m_owner].size() > 0)
      chk("tx_data", tx_data_o, exp_q[m_owner][0].d);
    if (reset_i) begin
      m_owner = -1;
      m_gap   = 0;
      m_cnt   = 0;
      m_last  = N - 1;
      m_trunc = 1'b0;
    end else begin
      m_trunc = 1'b0;
      if (m_owner >= 0) begin
        if (ev && tx_ready_i) begin
          b = exp_q[m_owner].pop_front();
          void'(src_q[m_owner].pop_front());
          m_cnt++;
          if (b.l || m_cnt == MAXB) begin
            m_trunc = !b.l;
            m_owner = -1;
            m_gap   = GAP;
          end
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        for (int i = 1; i <= N; i++) begin
          idx = (m_last + i) % N;
          if (m_owner < 0 && req_valid_i[idx]) m_owner = idx;
        end
        if (m_owner >= 0) begin
          m_last = m_owner;
          m_cnt  = 0;
        end
      end
    end
  end

  initial begin
    int n;
    reset_i     = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    tx_ready_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    drive();

    // Single 3-byte packet from requester 0
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b0);
    push_byte(0, 8'h43, 1'b1);
    run(20);
    chk("t1_sent", exp_q[0].size(), 0);

    // Two requesters out of reset
    do_reset();
    push_pkt(0, 1);
    push_pkt(2, 1);
    run(30);

    // All requesters continuously valid, 1-byte packets
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < N; k++) push_pkt(k, 1);
    run(120);

    // Stalled 2-byte packet on requester 1
    rdy_pct = 20;
    push_pkt(1, 2);
    run(80);
    rdy_pct = 100;

    // Over-long packet on requester 3 gets truncated
    push_pkt(3, 7);
    run(60);

    // Reset after the 2nd byte of a 5-byte packet
    push_pkt(0, 5);
    run(GAP + 4);
    for (int k = 1; k < N; k++) push_pkt(k, 2);
    n = 0;
    while (exp_q[0].size() > 3 && n < 200) begin
      @(posedge clk);
      #1 n++;
      if (exp_q[0].size() > 3) drive();
    end
    chk("t6_wait", (n < 200), 1);
    do_reset();
    run(60);

    // Random traffic
    pv      = 70;
    rdy_pct = 60;
    repeat (1500) begin
      if ($urandom_range(0, 99) < 5)
        push_pkt($urandom_range(0, N - 1), $urandom_range(1, 7));
      run(1);
    end

    // Drain
    pv      = 100;
    rdy_pct = 100;
    n = 0;
    while ((pending() > 0 || busy_o) && n < 3000) begin
      run(1);
      n++;
    end
    chk("drain_done", (pending() == 0 && !busy_o), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
